// File: rtl/bus_cycle_arbiter_pkg.sv
// Shared types and defaults for the C64-style bus cycle arbiter.
// Holds the arbiter state enum, timing defaults and the _AEC owner encoding.
package c64_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        STOLEN  = 2'd2
    } arb_state_t;

    localparam int TICKS_PER_CYCLE_DEF = 16;
    localparam int RAS_TICK_DEF        = 2;
    localparam int CAS_TICK_DEF        = 4;
    localparam int BA_LEAD_DEF         = 3;

    localparam logic AEC_CPU = 1'b0;
    localparam logic AEC_VIC = 1'b1;

    function automatic int tick_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_cycle_arbiter_if.sv
// Bus-side signals of the arbiter: the VIC request in, and the phase, strobe and ownership outputs.
// Handshake: vic_req is a level that is only sampled on the last tick of a phi cycle; BA/cpu_rdy low means the VIC owns or will own phi2.
interface bus_cycle_arbiter_if;
    import c64_bus_pkg::*;

    logic        vic_req;
    logic        stall_clr;
    logic        phi0;
    logic        phi2_ce;
    logic        _RAS;
    logic        _CAS;
    logic        _AEC;
    logic        BA;
    logic        cpu_rdy;
    logic [15:0] stall_cnt;
    arb_state_t  state;

    modport master (
        input  vic_req, stall_clr,
        output phi0, phi2_ce, _RAS, _CAS, _AEC, BA, cpu_rdy, stall_cnt, state
    );

    modport slave (
        output vic_req, stall_clr,
        input  phi0, phi2_ce, _RAS, _CAS, _AEC, BA, cpu_rdy, stall_cnt, state
    );

endinterface

// File: rtl/bus_cycle_arbiter_phase_timer.sv
// bus_phase_timer: tick counter plus registered phi0, phi2_ce and DRAM strobe decode.
// Every output is decoded from the next tick so it lines up with the registered tick value.
module bus_phase_timer
    import c64_bus_pkg::*;
#(
    parameter int TICKS_PER_CYCLE = TICKS_PER_CYCLE_DEF,
    parameter int RAS_TICK        = RAS_TICK_DEF,
    parameter int CAS_TICK        = CAS_TICK_DEF
) (
    input  logic clk,
    input  logic rst_n_i,
    output logic phi0_o,
    output logic phi2_ce_o,
    output logic ras_n_o,
    output logic cas_n_o,
    output logic phi1_next_o
);

    localparam int H  = TICKS_PER_CYCLE / 2;
    localparam int TW = tick_width(TICKS_PER_CYCLE);

    logic [TW-1:0] t_q, t_d, th_d;
    logic          phi0_q, ce_q, ras_n_q, cas_n_q;

    always_comb begin
        t_d  = (t_q == TW'(TICKS_PER_CYCLE - 1)) ? '0 : t_q + TW'(1);
        // Position within the current half; both halves share the strobe pattern.
        th_d = (t_d >= TW'(H)) ? t_d - TW'(H) : t_d;
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t_q     <= '0;
            phi0_q  <= 1'b0;
            ce_q    <= 1'b0;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
        end else begin
            t_q     <= t_d;
            phi0_q  <= (t_d >= TW'(H));
            ce_q    <= (t_d == TW'(TICKS_PER_CYCLE - 1));
            ras_n_q <= !(th_d >= TW'(RAS_TICK));
            cas_n_q <= !(th_d >= TW'(CAS_TICK));
        end
    end

    assign phi0_o      = phi0_q;
    assign phi2_ce_o   = ce_q;
    assign ras_n_o     = ras_n_q;
    assign cas_n_o     = cas_n_q;
    assign phi1_next_o = (t_d < TW'(H));

endmodule

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: phi1/phi2 bus sharing between CPU and VIC with BA lead-in cycle stealing.
// Optional stolen-phi2 counter is built only when BUS_ARB_STALL_COUNT_EN is defined.
module bus_cycle_arbiter
    import c64_bus_pkg::*;
#(
    parameter int TICKS_PER_CYCLE = TICKS_PER_CYCLE_DEF,
    parameter int RAS_TICK        = RAS_TICK_DEF,
    parameter int CAS_TICK        = CAS_TICK_DEF,
    parameter int BA_LEAD         = BA_LEAD_DEF
) (
    input  logic                 clk,
    input  logic                 _RESET,
    bus_cycle_arbiter_if.master  bus
);

    localparam logic [7:0] LC_LAST = 8'(BA_LEAD - 1);

    arb_state_t state_q, state_d;
    logic [7:0] lc_q, lc_d;
    logic       aec_q, aec_d;
    logic       ba_q, ba_d;
    logic       sample;
    logic       phi1_next;

    bus_phase_timer #(
        .TICKS_PER_CYCLE (TICKS_PER_CYCLE),
        .RAS_TICK        (RAS_TICK),
        .CAS_TICK        (CAS_TICK)
    ) u_timer (
        .clk         (clk),
        .rst_n_i     (_RESET),
        .phi0_o      (bus.phi0),
        .phi2_ce_o   (sample),
        .ras_n_o     (bus._RAS),
        .cas_n_o     (bus._CAS),
        .phi1_next_o (phi1_next)
    );

    // State only moves on the last tick, so state_d is already the state of the next tick.
    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        if (sample) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.vic_req) begin
                        state_d = PENDING;
                        lc_d    = '0;
                    end
                end
                PENDING: begin
                    if (!bus.vic_req)        state_d = IDLE;
                    else if (lc_q == LC_LAST) state_d = STOLEN;
                    else                      lc_d    = lc_q + 8'd1;
                end
                STOLEN: begin
                    if (!bus.vic_req) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        aec_d = phi1_next ? AEC_VIC : ((state_d == STOLEN) ? AEC_VIC : AEC_CPU);
        ba_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) begin
            state_q <= IDLE;
            lc_q    <= '0;
            aec_q   <= AEC_VIC;
            ba_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            aec_q   <= aec_d;
            ba_q    <= ba_d;
        end
    end

    assign bus.phi2_ce = sample;
    assign bus._AEC    = aec_q;
    assign bus.BA      = ba_q;
    assign bus.cpu_rdy = ba_q;
    assign bus.state   = state_q;

`ifdef BUS_ARB_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    // Clear has priority; count saturates rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        if (bus.stall_clr)
            stall_d = '0;
        else if (sample && (state_q == STOLEN) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign bus.stall_cnt = stall_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = bus.stall_clr;
    assign bus.stall_cnt    = '0;
`endif

endmodule
